// File: rtl/pattern_gen.sv
// Video test-pattern generator: dot grid, checkerboard, colour bars, solid.
// Mode changes and horizontal scroll take effect only at frame_start. Colour
// is produced by a 2-stage registered pipeline (x/y/de -> colour latency 2).
module pattern_gen #(
    parameter int          CELL_LOG2   = 2,
    parameter logic [3:0]  FG_R        = 4'hF,
    parameter logic [3:0]  FG_G        = 4'hF,
    parameter logic [3:0]  FG_B        = 4'hF,
    parameter logic [3:0]  BG_R        = 4'h0,
    parameter logic [3:0]  BG_G        = 4'h0,
    parameter logic [3:0]  BG_B        = 4'h0,
    parameter int          SCROLL_STEP = 1,
    parameter logic [1:0]  RESET_MODE  = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       de,
    input  logic       frame_start,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    input  logic       scroll_en,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       de_out,
    output logic [1:0] mode,
    output logic       mode_ack
);

    localparam logic [9:0] STEP      = 10'(SCROLL_STEP);
    localparam logic [9:0] CELL_MASK = 10'((1 << CELL_LOG2) - 1);

    // Frame-synchronous control state
    logic [1:0] r_mode;
    logic [1:0] r_pend_mode;
    logic       r_pend;
    logic       r_ack;
    logic [9:0] r_offset;

    // Stage 1 pixel snapshot
    logic [9:0] r_s1_xe;
    logic [9:0] r_s1_y;
    logic       r_s1_de;
    logic [1:0] r_s1_mode;

    // Stage 2 outputs
    logic [3:0] r_red;
    logic [3:0] r_green;
    logic [3:0] r_blue;
    logic       r_de_out;

    logic       w_apply;
    logic [1:0] w_new_mode;
    logic [9:0] w_xe;
    logic [2:0] w_bar;
    logic       w_dot;
    logic       w_check;
    logic [3:0] w_red;
    logic [3:0] w_green;
    logic [3:0] w_blue;
    logic       w_unused_y;

    // A same-cycle request at the boundary bypasses the pending register
    assign w_apply    = frame_start & (r_pend | mode_valid);
    assign w_new_mode = mode_valid ? mode_req : r_pend_mode;
    assign w_xe       = x + r_offset;
    assign w_bar      = r_s1_xe[9:7];
    assign w_dot      = ((r_s1_xe & CELL_MASK) == 10'd0) && ((r_s1_y & CELL_MASK) == 10'd0);
    assign w_check    = (r_s1_xe[CELL_LOG2] ^ r_s1_y[CELL_LOG2]) == 1'b0;
    assign w_unused_y = &{1'b0, r_s1_y[9:CELL_LOG2+1]};

    // Mode request capture, boundary apply, ack pulse and scroll offset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode      <= RESET_MODE;
            r_pend_mode <= 2'd0;
            r_pend      <= 1'b0;
            r_ack       <= 1'b0;
            r_offset    <= 10'd0;
        end else begin
            r_ack <= w_apply;
            if (frame_start) begin
                if (w_apply) begin
                    r_mode <= w_new_mode;
                end
                r_pend <= 1'b0;
            end else if (mode_valid) begin
                r_pend_mode <= mode_req;
                r_pend      <= 1'b1;
            end
            if (frame_start && scroll_en) begin
                r_offset <= r_offset + STEP;
            end
        end
    end

    // Stage 1: scrolled column, row, qualifier and per-pixel mode snapshot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_xe   <= 10'd0;
            r_s1_y    <= 10'd0;
            r_s1_de   <= 1'b0;
            r_s1_mode <= 2'd0;
        end else begin
            r_s1_xe   <= w_xe;
            r_s1_y    <= y;
            r_s1_de   <= de;
            r_s1_mode <= r_mode;
        end
    end

    // Pattern colour selection from the stage-1 snapshot
    always_comb begin
        w_red   = BG_R;
        w_green = BG_G;
        w_blue  = BG_B;
        case (r_s1_mode)
            2'd0: if (w_dot) begin
                w_red = FG_R; w_green = FG_G; w_blue = FG_B;
            end
            2'd1: if (w_check) begin
                w_red = FG_R; w_green = FG_G; w_blue = FG_B;
            end
            2'd2: begin
                w_red   = {4{w_bar[2]}};
                w_green = {4{w_bar[1]}};
                w_blue  = {4{w_bar[0]}};
            end
            default: begin
                w_red = FG_R; w_green = FG_G; w_blue = FG_B;
            end
        endcase
        if (!r_s1_de) begin
            w_red   = 4'd0;
            w_green = 4'd0;
            w_blue  = 4'd0;
        end
    end

    // Stage 2: registered colour and aligned de
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_red    <= 4'd0;
            r_green  <= 4'd0;
            r_blue   <= 4'd0;
            r_de_out <= 1'b0;
        end else begin
            r_red    <= w_red;
            r_green  <= w_green;
            r_blue   <= w_blue;
            r_de_out <= r_s1_de;
        end
    end

    assign red      = r_red;
    assign green    = r_green;
    assign blue     = r_blue;
    assign de_out   = r_de_out;
    assign mode     = r_mode;
    assign mode_ack = r_ack;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen (CELL_LOG2=2, SCROLL_STEP=1000).
// Pixel expectations travel through exp_q ({de_out,r,g,b}); each pixel's
// colour is checked one pixel later, i.e. two clock edges after it was driven.
module tb_pattern_gen;

    localparam logic [12:0] FG  = 13'h1FFF;
    localparam logic [12:0] BG  = 13'h1000;
    localparam logic [12:0] OFF = 13'h0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       de, frame_start, mode_valid, scroll_en;
    logic [1:0] mode_req;
    logic [3:0] red, green, blue;
    logic       de_out, mode_ack;
    logic [1:0] mode;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [12:0] exp_q[$];

    // Clock and DUT
    always #5 clk = ~clk;

    pattern_gen #(.SCROLL_STEP(1000)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de),
        .frame_start(frame_start), .mode_req(mode_req), .mode_valid(mode_valid),
        .scroll_en(scroll_en), .red(red), .green(green), .blue(blue),
        .de_out(de_out), .mode(mode), .mode_ack(mode_ack)
    );

    function automatic logic [12:0] bar_exp(input logic [2:0] b);
        return {1'b1, {4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] e);
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Drive one pixel for one clock; score the pixel driven one step earlier
    task automatic px(input logic [9:0] xx, input logic [9:0] yy, input logic d,
                      input logic [12:0] e);
        logic [12:0] ex;
        x = xx; y = yy; de = d;
        exp_q.push_back(e);
        @(posedge clk); #1;
        frame_start = 1'b0;
        mode_valid  = 1'b0;
        if (exp_q.size() == 2) begin
            ex = exp_q.pop_front();
            chk("pixel", {de_out, red, green, blue}, ex);
        end
    endtask

    initial begin
        rst_n = 1'b0; x = '0; y = '0; de = 1'b0; frame_start = 1'b0;
        mode_valid = 1'b0; mode_req = 2'd0; scroll_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_colour", {de_out, red, green, blue}, OFF);
        chk("rst_mode", 13'(mode), 13'd0);
        chk("rst_ack", 13'(mode_ack), 13'd0);
        rst_n = 1'b1;

        // Dot grid sweep: fg at x=0,4 on y=0, all bg on y=1
        for (int i = 0; i < 8; i++) px(10'(i), 10'd0, 1'b1, (i == 0 || i == 4) ? FG : BG);
        for (int i = 0; i < 8; i++) px(10'(i), 10'd1, 1'b1, BG);

        // Mid-frame request held until frame_start
        mode_valid = 1'b1; mode_req = 2'd1;
        px(10'd0, 10'd0, 1'b0, OFF);
        for (int i = 0; i < 100; i++) px(10'd0, 10'd0, 1'b0, OFF);
        chk("mode_hold", 13'(mode), 13'd0);
        chk("ack_idle", 13'(mode_ack), 13'd0);
        frame_start = 1'b1;
        px(10'd0, 10'd0, 1'b0, OFF);
        chk("mode_apply1", 13'(mode), 13'd1);
        chk("ack_pulse1", 13'(mode_ack), 13'd1);
        px(10'd0, 10'd0, 1'b0, OFF);
        chk("ack_single", 13'(mode_ack), 13'd0);
        px(10'd4, 10'd0, 1'b1, BG);
        px(10'd4, 10'd4, 1'b1, FG);
        px(10'd3, 10'd0, 1'b1, FG);
        px(10'd0, 10'd0, 1'b0, OFF);

        // Request coincident with frame_start, then colour-bar sweep
        mode_valid = 1'b1; mode_req = 2'd2; frame_start = 1'b1;
        px(10'd0, 10'd0, 1'b0, OFF);
        chk("mode_apply2", 13'(mode), 13'd2);
        chk("ack_pulse2", 13'(mode_ack), 13'd1);
        for (int i = 0; i < 1024; i++) px(10'(i), 10'd0, 1'b1, bar_exp(3'(i >> 7)));

        // Scroll by 1000 three times: offset 1000, 976, 952
        scroll_en = 1'b1;
        repeat (3) begin
            frame_start = 1'b1;
            px(10'd0, 10'd0, 1'b0, OFF);
        end
        scroll_en = 1'b0;
        chk("ack_no_pend", 13'(mode_ack), 13'd0);
        chk("mode_keep2", 13'(mode), 13'd2);
        px(10'd0, 10'd0, 1'b1, FG);           // xe=952  -> bar 7
        px(10'd71, 10'd0, 1'b1, FG);          // xe=1023 -> bar 7
        px(10'd72, 10'd0, 1'b1, BG);          // xe wraps to 0 -> bar 0
        px(10'd200, 10'd0, 1'b1, 13'h100F);   // xe=128  -> bar 1 (blue)
        frame_start = 1'b1;                   // scroll disabled: offset holds
        px(10'd0, 10'd0, 1'b0, OFF);
        px(10'd72, 10'd0, 1'b1, BG);

        // de low for exactly three pixels mid-line
        for (int i = 0; i < 8; i++)
            px(10'(i), 10'd2, !(i >= 3 && i <= 5), (i >= 3 && i <= 5) ? OFF : FG);
        px(10'd0, 10'd0, 1'b0, OFF);

        // Solid mode, a pending request, then a one-cycle reset mid-frame
        mode_valid = 1'b1; mode_req = 2'd3; frame_start = 1'b1;
        px(10'd0, 10'd0, 1'b0, OFF);
        chk("mode_apply3", 13'(mode), 13'd3);
        mode_valid = 1'b1; mode_req = 2'd1;
        px(10'd5, 10'd5, 1'b1, FG);
        px(10'd6, 10'd6, 1'b1, FG);
        rst_n = 1'b0; x = 10'd7; y = 10'd7; de = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_colour", {de_out, red, green, blue}, OFF);
        chk("rst_mid_mode", 13'(mode), 13'd0);
        chk("rst_mid_ack", 13'(mode_ack), 13'd0);
        exp_q.delete();
        exp_q.push_back(OFF);
        rst_n = 1'b1;
        px(10'd0, 10'd0, 1'b0, OFF);
        frame_start = 1'b1;
        px(10'd0, 10'd0, 1'b0, OFF);
        chk("pend_dropped_ack", 13'(mode_ack), 13'd0);
        chk("pend_dropped_mode", 13'(mode), 13'd0);
        mode_valid = 1'b1; mode_req = 2'd2; frame_start = 1'b1;
        px(10'd0, 10'd0, 1'b0, OFF);
        chk("mode_apply4", 13'(mode), 13'd2);
        px(10'd0, 10'd0, 1'b1, BG);           // offset back to 0 -> bar 0
        px(10'd900, 10'd0, 1'b1, FG);         // bar 7
        px(10'd0, 10'd0, 1'b0, OFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Parametrised video test-pattern generator; successor to the fixed dot-grid colour generator.
- Sits between the VGA timing counters (x, y, de, frame_start) and the colour output mux.
- Four selectable patterns: dot grid, checkerboard, colour bars, solid.
- Mode changes and horizontal scroll are applied only at frame boundaries, so no frame tears. Output is a registered 2-stage pipeline.

Parameters:
- CELL_LOG2, 2, log2 of cell size in pixels for grid/checker modes (cell = 2^CELL_LOG2).
- FG_R, 4'hF, foreground red.
- FG_G, 4'hF, foreground green.
- FG_B, 4'hF, foreground blue.
- BG_R, 4'h0, background red.
- BG_G, 4'h0, background green.
- BG_B, 4'h0, background blue.
- SCROLL_STEP, 1, pixels added to the scroll offset per frame when scrolling (0..1023).
- RESET_MODE, 2'd0, mode after reset.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, synchronous active-low reset.
- x, input, 10, current pixel column.
- y, input, 10, current pixel row.
- de, input, 1, active-video qualifier for x/y.
- frame_start, input, 1, one-cycle pulse at start of frame.
- mode_req, input, 2, requested pattern mode.
- mode_valid, input, 1, strobe; captures mode_req.
- scroll_en, input, 1, enables offset advance at frame_start.
- red, output, 4, pixel red.
- green, output, 4, pixel green.
- blue, output, 4, pixel blue.
- de_out, output, 1, de delayed to align with colour.
- mode, output, 2, mode currently in effect.
- mode_ack, output, 1, one-cycle pulse when a pending mode is applied.

Behaviour:
- Reset (rst_n low at posedge): red/green/blue=0, de_out=0, mode_ack=0, mode=RESET_MODE, offset=0, pending flag cleared. Any in-flight pipeline data is discarded.
- Mode request handling:
  - mode_valid high: pending_mode<=mode_req, pending<=1.
  - A later request before the frame boundary overwrites the earlier one (last wins).
- At frame_start, if pending (or mode_valid in the same cycle, in which case mode_req is used directly):
  - mode<=new value, pending<=0.
  - mode_ack=1 on the next cycle, for exactly 1 cycle.
  - mode_ack pulses even if the new mode equals the current mode.
- Scroll: at frame_start with scroll_en=1, offset<=(offset+SCROLL_STEP) mod 1024. With scroll_en=0, offset holds.
- New mode and new offset apply to pixels sampled from the cycle after frame_start onward.
- Stage 1 registers:
  - xe=(x+offset) mod 1024 (10-bit wrap).
  - y, de, mode snapshot.
- Stage 2 registers the colour and de_out. Latency from x/y/de to colour is exactly 2 cycles.
- Patterns, where fg = (FG_R,FG_G,FG_B) and bg = (BG_R,BG_G,BG_B):
  - Mode 0, dot grid: fg when xe[CELL_LOG2-1:0]==0 and y[CELL_LOG2-1:0]==0, else bg.
  - Mode 1, checkerboard: fg when xe[CELL_LOG2]^y[CELL_LOG2]==0, else bg.
  - Mode 2, colour bars: b=xe[9:7]; red=b[2]?F:0, green=b[1]?F:0, blue=b[0]?F:0. Gives 8 bars, each 128 px wide.
  - Mode 3, solid: fg.
- de low at stage 2 input: red/green/blue=0 and de_out=0, regardless of mode.
- The mode snapshot is per-pixel, so a mode change can never split a pixel across two modes.
- Reset mid-frame: outputs are 0 from the cycle after the reset edge. Normal output resumes 2 cycles after rst_n rises.

Test Plan:
- Reset, mode 0, CELL_LOG2=2, de=1, sweep x=0..7 at y=0 → 2 cycles later colour is F,F,F at x=0 and x=4 and 0,0,0 elsewhere; y=1 gives all bg.
- mode_valid with mode_req=1 mid-frame, then frame_start 100 cycles later → mode stays 0 until frame_start; mode=1 and mode_ack=1 for one cycle after it; pixel (4,0) gives bg and (4,4) gives fg.
- mode_valid=1 with mode_req=2 in the same cycle as frame_start → applied at that boundary; x=0..1023 gives colour (0,0,0) at x=0..127 and (F,F,F) at x=896..1023.
- scroll_en=1, SCROLL_STEP=1000, three frame_starts → offset 0→1000→976→952; in mode 2, x=0 yields bar index (952>>7)=7.
- Toggle de low for 3 cycles mid-line → de_out low and colour 0 for exactly 3 cycles, delayed 2 cycles.
- Assert rst_n low mid-frame for 1 cycle in mode 3 with offset≠0 → next-cycle outputs 0, mode=RESET_MODE, offset=0, pending request dropped (no mode_ack at next frame_start).
